// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier.
// One Booth iteration per clock, using a single 2*WIDTH-bit two's-complement adder
// (a + b + cin). The product is registered and held until the next completion.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; product holds the last result
// S_RUN  | WIDTH Booth iterations in progress; busy=1
// S_DONE | single-cycle completion; done=1; start accepted again here

module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mr;
    logic [WIDTH-1:0] qr;
    logic             q_1;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    add_a;
    logic [PW-1:0]    m_ext;
    logic [PW-1:0]    add_b;
    logic [PW-1:0]    add_sum;
    logic             add_cin;
    logic             do_add;
    logic             do_sub;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH-1:0] qr_sh;
    logic             q1_sh;
    logic             adder_unused;

    // Booth recode of {Qr[0], q_1}, shared adder, then arithmetic shift right by one
    always_comb begin
        do_add   = ~qr[0] & q_1;
        do_sub   = qr[0] & ~q_1;
        add_a    = {{(PW-WIDTH-1){acc[WIDTH]}}, acc};
        m_ext    = {{(PW-WIDTH-1){mr[WIDTH]}}, mr};
        add_b    = '0;
        if (do_sub) begin
            add_b = ~m_ext;
        end else if (do_add) begin
            add_b = m_ext;
        end
        add_cin  = do_sub;
        add_sum  = add_a + add_b + {{(PW-1){1'b0}}, add_cin};
        acc_next = add_sum[WIDTH:0];
        acc_sh   = {acc_next[WIDTH], acc_next[WIDTH:1]};
        qr_sh    = {acc_next[0], qr[WIDTH-1:1]};
        q1_sh    = qr[0];
    end

    // Carry-out and the upper sign-extension bits carry no information here
    assign adder_unused = ^add_sum[PW-1:WIDTH+1];

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mr      <= '0;
            qr      <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mr    <= {multiplicand[WIDTH-1], multiplicand};
                        qr    <= multiplier;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc <= acc_sh;
                    qr  <= qr_sh;
                    q_1 <= q1_sh;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Low 2*WIDTH bits of the shifted {A, Qr}
                        product <= {acc_next, qr[WIDTH-1:1]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed cases followed by
// back-to-back random operand pairs against a plain signed-multiply model.

module tb_booth_seq_mult;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed product truncated to 2*W bits
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        longint pm;
        longint pq;
        longint p;
        pm = longint'($signed(m));
        pq = longint'($signed(q));
        p  = pm * pq;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accepting edge, then scramble the inputs
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        tick();
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q);
        int e;
        int b;
        start_op(m, q);
        wait_done(e, b);
        check({tag, "_latency"}, 64'(e), 64'd16);
        check({tag, "_product"}, 64'(product), 64'(ref_mul(m, q)));
        tick();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int e;
        int b;
        int ndone;
        logic [W-1:0]   rm;
        logic [W-1:0]   rq;
        logic [2*W-1:0] rexp;
        int since_done;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst_n = 1'b1;

        // 3 * 5 with busy and latency accounting
        start_op(16'd3, 16'd5);
        check("t1_busy_after_accept", 64'(busy), 64'd1);
        wait_done(e, b);
        check("t1_latency", 64'(e), 64'd16);
        check("t1_busy_cycles", 64'(b), 64'd16);
        check("t1_busy_low_at_done", 64'(busy), 64'd0);
        check("t1_product", 64'(product), 64'h0000000F);
        tick();
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_product_held", 64'(product), 64'h0000000F);

        // Mixed signs and extreme operands
        do_op("t2_m7x6", 16'hFFF9, 16'd6);
        check("t2_const", 64'(product), 64'hFFFFFFD6);
        do_op("t2_6xm7", 16'd6, 16'hFFF9);
        check("t2b_const", 64'(product), 64'hFFFFFFD6);
        do_op("t3_min_min", 16'h8000, 16'h8000);
        check("t3_min_min_const", 64'(product), 64'h40000000);
        do_op("t3_max_min", 16'h7FFF, 16'h8000);
        check("t3_max_min_const", 64'(product), 64'hC0008000);
        do_op("t3_zero_min", 16'h0000, 16'h8000);
        check("t3_zero_const", 64'(product), 64'h00000000);

        // start while busy is ignored; start during DONE is accepted back-to-back
        start_op(16'd3, 16'd5);
        repeat (4) tick();
        start        = 1'b1;
        multiplicand = 16'd9;
        multiplier   = 16'd9;
        tick();
        start        = 1'b0;
        wait_done(e, b);
        check("t4_latency_rest", 64'(e), 64'd11);
        check("t4_product", 64'(product), 64'h0000000F);
        start_op(16'hFFFF, 16'hFFFF);
        check("t4_no_double_done", 64'(done), 64'd0);
        check("t4_b2b_busy", 64'(busy), 64'd1);
        wait_done(e, b);
        check("t4_b2b_latency", 64'(e), 64'd16);
        check("t4_b2b_product", 64'(product), 64'h00000001);
        tick();
        check("t4_idle_done", 64'(done), 64'd0);
        check("t4_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of an operation
        start_op(16'd100, 16'd200);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_product", 64'(product), 64'd0);
        #3;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("t5_no_done_after_rst", 64'(ndone), 64'd0);
        do_op("t5_fresh", 16'd2, 16'hFFFD);
        check("t5_fresh_const", 64'(product), 64'hFFFFFFFA);

        // Back-to-back random operands, corners mixed in
        rm = W'($urandom);
        rq = W'($urandom);
        rexp = ref_mul(rm, rq);
        start_op(rm, rq);
        since_done = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_done(e, b);
            check("t6_latency", 64'(e), 64'd16);
            if (i > 0) check("t6_spacing", 64'(since_done + e), 64'd17);
            check("t6_product", 64'(product), 64'(rexp));
            if (i < 999) begin
                rm = ($urandom_range(0, 7) == 0) ? W'(16'h8000) : W'($urandom);
                rq = ($urandom_range(0, 7) == 0) ? W'(16'h8000) : W'($urandom);
                if ($urandom_range(0, 15) == 0) rq = W'(16'h7FFF);
                rexp = ref_mul(rm, rq);
                start_op(rm, rq);
                since_done = 1;
            end
        end
        tick();
        check("t6_final_done", 64'(done), 64'd0);
        check("t6_final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
